// File: rtl/display_color_pipeline.sv
// Gamma + brightness colour pipeline: segments x channels lanes per word, 3 en-qualified stages.
// en=0 freezes all stages (outputs hold); brightness commits only on an accepted first-of-frame word.
module display_color_pipeline #(
    parameter int segments = 2,
    parameter int channels = 3,
    parameter int in_bits  = 8,
    parameter int out_bits = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  en,
    input  logic                                  in_valid,
    input  logic                                  in_first,
    input  logic [segments*channels*in_bits-1:0]  pixel,
    input  logic                                  gamma_en,
    input  logic [7:0]                            brightness,
    input  logic                                  brightness_load,
    output logic                                  out_valid,
    output logic                                  out_first,
    output logic [segments*channels*out_bits-1:0] cpixel
);

    localparam int lanes = segments * channels;
    localparam int pw    = lanes * in_bits;
    localparam int ow    = lanes * out_bits;

    if (out_bits < 1 || out_bits > in_bits) begin : g_bad_width
        $error("display_color_pipeline: out_bits must be in 1..in_bits");
    end

    // x*(x+1) >> n tops out at exactly 2^n-1, so the result always fits in n bits.
    function automatic logic [in_bits-1:0] gamma_fn(input logic [in_bits-1:0] x,
                                                    input logic on);
        logic [2*in_bits-1:0] xe;
        logic [2*in_bits-1:0] sq;
        xe = (2*in_bits)'(x);
        sq = xe * xe + xe;
        return on ? in_bits'(sq >> in_bits) : x;
    endfunction

    function automatic logic [out_bits-1:0] scale_fn(input logic [in_bits-1:0] g,
                                                     input logic [7:0] b);
        logic [in_bits+8:0] ge;
        logic [in_bits+8:0] be;
        logic [in_bits+8:0] prod;
        logic [in_bits-1:0] s;
        ge   = (in_bits+9)'(g);
        be   = (in_bits+9)'(b) + (in_bits+9)'(1);
        prod = ge * be;
        s    = in_bits'(prod >> 8);
        return out_bits'(s >> (in_bits - out_bits));
    endfunction

    logic [7:0] bright_pend;
    logic       pend_flag;
    logic [7:0] bright_act;
    logic       commit;
    logic [7:0] b_tag;

    // The committing word itself must see the new value, hence the bypass.
    assign commit = en & in_valid & in_first & pend_flag;
    assign b_tag  = commit ? bright_pend : bright_act;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bright_pend <= 8'hFF;
            pend_flag   <= 1'b0;
            bright_act  <= 8'hFF;
        end else begin
            if (brightness_load) begin
                bright_pend <= brightness;
                pend_flag   <= 1'b1;
            end else if (commit) begin
                pend_flag <= 1'b0;
            end
            if (commit) begin
                bright_act <= bright_pend;
            end
        end
    end

    logic          s1_valid;
    logic          s1_first;
    logic [pw-1:0] s1_pix;
    logic [7:0]    s1_b;
    logic          s1_gamma;

    logic          s2_valid;
    logic          s2_first;
    logic [pw-1:0] s2_g;
    logic [7:0]    s2_b;

    logic [pw-1:0] gamma_out;
    logic [ow-1:0] scale_out;

    always_comb begin
        gamma_out = '0;
        for (int l = 0; l < lanes; l++) begin
            gamma_out[l*in_bits +: in_bits] = gamma_fn(s1_pix[l*in_bits +: in_bits], s1_gamma);
        end
    end

    always_comb begin
        scale_out = '0;
        for (int l = 0; l < lanes; l++) begin
            scale_out[l*out_bits +: out_bits] = scale_fn(s2_g[l*in_bits +: in_bits], s2_b);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_pix    <= '0;
            s1_b      <= 8'h00;
            s1_gamma  <= 1'b0;
            s2_valid  <= 1'b0;
            s2_first  <= 1'b0;
            s2_g      <= '0;
            s2_b      <= 8'h00;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            cpixel    <= '0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s1_first  <= in_valid & in_first;
            s1_pix    <= pixel;
            s1_b      <= b_tag;
            s1_gamma  <= gamma_en;
            s2_valid  <= s1_valid;
            s2_first  <= s1_first;
            s2_g      <= gamma_out;
            s2_b      <= s1_b;
            out_valid <= s2_valid;
            out_first <= s2_first;
            cpixel    <= scale_out;
        end
    end

endmodule

// File: tb/tb_display_color_pipeline.sv
// Directed-vector bench for display_color_pipeline (default geometry plus a 4-segment, 5-bit instance).
module tb_display_color_pipeline;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_first = 1'b0;
    logic [47:0] pixel = '0;
    logic        gamma_en = 1'b0;
    logic [7:0]  brightness = 8'h00;
    logic        brightness_load = 1'b0;
    logic        out_valid;
    logic        out_first;
    logic [47:0] cpixel;

    logic        in_valid2 = 1'b0;
    logic [95:0] pixel2 = '0;
    logic        out_valid2;
    logic        out_first2;
    logic [59:0] cpixel2;

    always #5 clk = ~clk;

    display_color_pipeline dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_first(in_first),
        .pixel(pixel), .gamma_en(gamma_en), .brightness(brightness),
        .brightness_load(brightness_load), .out_valid(out_valid), .out_first(out_first),
        .cpixel(cpixel)
    );

    display_color_pipeline #(.segments(4), .channels(3), .in_bits(8), .out_bits(5)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid2), .in_first(1'b0),
        .pixel(pixel2), .gamma_en(1'b1), .brightness(8'h00),
        .brightness_load(1'b0), .out_valid(out_valid2), .out_first(out_first2),
        .cpixel(cpixel2)
    );

    typedef struct packed {
        logic        vld;
        logic        first;
        logic [47:0] pix;
    } exp_t;

    typedef struct {
        logic        g;
        logic [47:0] pix;
        logic [47:0] exp;
    } vec_t;

    exp_t exp_s [3];
    exp_t nxt;
    vec_t tbl [6];
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic [47:0] ALL_FF = 48'hFFFFFF_FFFFFF;
    localparam logic [47:0] ALL_7F = 48'h7F7F7F_7F7F7F;
    localparam logic [47:0] ALL_3F = 48'h3F3F3F_3F3F3F;
    localparam logic [47:0] ALL_1F = 48'h1F1F1F_1F1F1F;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected words travel through a 3-deep delay line that advances only with en.
    task automatic tick();
        @(posedge clk);
        #1;
        if (en) begin
            exp_s[2] = exp_s[1];
            exp_s[1] = exp_s[0];
            exp_s[0] = nxt;
        end
        chk("out_valid", 64'(out_valid), 64'(exp_s[2].vld));
        if (exp_s[2].vld) begin
            chk("out_first", 64'(out_first), 64'(exp_s[2].first));
            chk("cpixel", 64'(cpixel), 64'(exp_s[2].pix));
        end
    endtask

    task automatic word(input logic v, input logic f, input logic g,
                        input logic [47:0] p, input logic [47:0] e);
        in_valid  = v;
        in_first  = f;
        gamma_en  = g;
        pixel     = p;
        nxt.vld   = v;
        nxt.first = v & f;
        nxt.pix   = e;
        tick();
    endtask

    task automatic bubbles(input int n);
        for (int i = 0; i < n; i++) word(1'b0, 1'b0, 1'b0, 48'h0, 48'h0);
    endtask

    // Asserts reset between clock edges and checks the outputs clear without waiting for an edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst out_valid", 64'(out_valid), 64'h0);
        chk("rst out_first", 64'(out_first), 64'h0);
        chk("rst cpixel", 64'(cpixel), 64'h0);
        chk("rst out_valid2", 64'(out_valid2), 64'h0);
        chk("rst cpixel2", 64'(cpixel2), 64'h0);
        for (int i = 0; i < 3; i++) exp_s[i] = '0;
        nxt             = '0;
        in_valid        = 1'b0;
        in_first        = 1'b0;
        brightness_load = 1'b0;
        en              = 1'b1;
        in_valid2       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] in_lane  [12];
        logic [4:0] exp_lane [12];
        logic [59:0] exp2;

        tbl[0] = '{1'b1, 48'hFFFFFF_000000, 48'hFFFFFF_000000};
        tbl[1] = '{1'b1, 48'h808080_101010, 48'h404040_010101};
        tbl[2] = '{1'b0, 48'h123456_ABCDEF, 48'h123456_ABCDEF};
        tbl[3] = '{1'b1, 48'h4020C0_FF8010, 48'h100490_FF4001};
        tbl[4] = '{1'b0, 48'h808080_FF0001, 48'h808080_FF0001};
        tbl[5] = '{1'b1, 48'hFEFEFE_010101, 48'hFDFDFD_000000};

        in_lane  = '{8'h00, 8'h80, 8'hFF, 8'hC0, 8'h20, 8'h40,
                     8'h80, 8'hFF, 8'h10, 8'hFF, 8'hC0, 8'h00};
        exp_lane = '{5'h00, 5'h08, 5'h1F, 5'h12, 5'h00, 5'h02,
                     5'h08, 5'h1F, 5'h00, 5'h1F, 5'h12, 5'h00};

        for (int i = 0; i < 3; i++) exp_s[i] = '0;
        nxt = '0;
        #1;
        do_reset();

        // Default brightness, back-to-back words with gamma toggling per word.
        for (int i = 0; i < 6; i++) word(1'b1, 1'b0, tbl[i].g, tbl[i].pix, tbl[i].exp);
        bubbles(2);

        // Load without first-of-frame leaves output alone; the next first word commits 0x7F.
        brightness = 8'h7F;
        brightness_load = 1'b1;
        word(1'b1, 1'b0, 1'b0, ALL_FF, ALL_FF);
        brightness_load = 1'b0;
        word(1'b1, 1'b0, 1'b0, ALL_FF, ALL_FF);
        word(1'b1, 1'b1, 1'b0, ALL_FF, ALL_7F);
        word(1'b1, 1'b0, 1'b0, 48'h808080_808080, 48'h404040_404040);

        // Load coinciding with commit: commit takes the old pending value, new load stays pending.
        brightness = 8'h3F;
        brightness_load = 1'b1;
        word(1'b0, 1'b0, 1'b0, 48'h0, 48'h0);
        brightness = 8'h1F;
        word(1'b1, 1'b1, 1'b0, ALL_FF, ALL_3F);
        brightness_load = 1'b0;
        word(1'b1, 1'b0, 1'b0, ALL_FF, ALL_3F);
        word(1'b1, 1'b1, 1'b0, ALL_FF, ALL_1F);
        bubbles(2);

        // Mid-frame load waits for the next frame start.
        do_reset();
        word(1'b1, 1'b1, 1'b0, ALL_FF, ALL_FF);
        brightness = 8'h3F;
        brightness_load = 1'b1;
        word(1'b1, 1'b0, 1'b0, ALL_FF, ALL_FF);
        brightness_load = 1'b0;
        word(1'b1, 1'b0, 1'b0, ALL_FF, ALL_FF);
        word(1'b1, 1'b1, 1'b0, ALL_FF, ALL_3F);
        word(1'b1, 1'b0, 1'b0, ALL_FF, ALL_3F);
        bubbles(2);

        // Stall: outputs hold, commit is blocked but the load still lands in the pending register.
        do_reset();
        word(1'b1, 1'b0, 1'b0, 48'h112233_445566, 48'h112233_445566);
        word(1'b1, 1'b0, 1'b1, 48'h808080_101010, 48'h404040_010101);
        word(1'b1, 1'b0, 1'b0, 48'h010203_FEFDFC, 48'h010203_FEFDFC);
        en = 1'b0;
        brightness = 8'h3F;
        brightness_load = 1'b1;
        word(1'b1, 1'b1, 1'b0, ALL_FF, ALL_FF);
        brightness_load = 1'b0;
        word(1'b1, 1'b1, 1'b0, ALL_FF, ALL_FF);
        word(1'b1, 1'b1, 1'b0, ALL_FF, ALL_FF);
        word(1'b1, 1'b1, 1'b0, ALL_FF, ALL_FF);
        en = 1'b1;
        word(1'b1, 1'b0, 1'b0, ALL_FF, ALL_FF);
        word(1'b0, 1'b0, 1'b0, 48'h0, 48'h0);
        word(1'b1, 1'b1, 1'b0, ALL_FF, ALL_3F);
        bubbles(3);

        // Narrow-output, four-segment instance with distinct per-lane codes.
        exp2 = '0;
        for (int l = 0; l < 12; l++) begin
            pixel2[l*8 +: 8] = in_lane[l];
            exp2[l*5 +: 5]   = exp_lane[l];
        end
        chk("out_valid2 idle", 64'(out_valid2), 64'h0);
        in_valid2 = 1'b1;
        tick();
        in_valid2 = 1'b0;
        tick();
        chk("out_valid2 early", 64'(out_valid2), 64'h0);
        tick();
        chk("out_valid2", 64'(out_valid2), 64'h1);
        chk("out_first2", 64'(out_first2), 64'h0);
        chk("cpixel2", 64'(cpixel2), 64'(exp2));
        tick();
        chk("out_valid2 bubble", 64'(out_valid2), 64'h0);

        // Async reset with words in flight and a brightness load still pending.
        brightness = 8'h1F;
        brightness_load = 1'b1;
        word(1'b1, 1'b0, 1'b0, ALL_FF, ALL_3F);
        brightness_load = 1'b0;
        word(1'b1, 1'b0, 1'b0, 48'h808080_808080, 48'h202020_202020);
        word(1'b1, 1'b0, 1'b0, ALL_FF, ALL_3F);
        do_reset();
        bubbles(3);
        word(1'b1, 1'b1, 1'b0, ALL_FF, ALL_FF);
        word(1'b1, 1'b0, 1'b1, 48'h808080_101010, 48'h404040_010101);
        bubbles(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/display_color_pipeline.md
# display_color_pipeline

Parametrised successor to the display colour encoder: converts `segments` packed RGB pixels per cycle from linear input code to gamma-corrected, brightness-scaled output code of a configurable width. The block sits between the framebuffer read path and the panel shift-out logic. It is a 3-stage pipeline with valid/first-of-frame tagging. A frame-synchronous brightness register guarantees that a brightness change never splits a frame.

## Interface
- `segments`, 2, pixels processed in parallel per cycle
- `channels`, 3, colour channels per pixel; channel 0 is the LSB field
- `in_bits`, 8, input bits per channel
- `out_bits`, 8, output bits per channel; must satisfy 1 ≤ `out_bits` ≤ `in_bits`

- `clk`  in  1  clock; all state changes on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  pipeline advance; when 0, all pipeline registers hold
- `in_valid`  in  1  `pixel` carries data this cycle
- `in_first`  in  1  first pixel word of a frame; qualified by `in_valid`
- `pixel`  in  segments*channels*in_bits  packed input; segment 0 is the LSB field
- `gamma_en`  in  1  1 = gamma on; 0 = linear passthrough, with brightness still applied
- `brightness`  in  8  new brightness value
- `brightness_load`  in  1  latch `brightness` into the pending register
- `out_valid`  out  1  `cpixel` is valid
- `out_first`  out  1  `in_first` delayed alongside the data
- `cpixel`  out  segments*channels*out_bits  packed output, same ordering as `pixel`

## Operation
- Per-channel function, with x = input channel code and n = `in_bits`:
  - g = gamma_en ? ((x*x + x) >> n) : x. The result is n bits wide; the maximum is exactly 2^n−1.
  - s = (g * (B + 1)) >> 8, n bits wide, where B is the brightness tagged on that word.
  - out = s >> (n − `out_bits`), which keeps the MSBs. No rounding anywhere; truncation only.
- All segments×channels lanes are computed in parallel with identical logic.
- Brightness registers:
  - `bright_pend`: reset value 0xFF.
  - `pend_flag`: reset value 0.
  - `bright_act`: reset value 0xFF.
- `brightness_load`=1 sets `bright_pend` ← `brightness` and `pend_flag` ← 1. This is independent of `en`.
- Commit: on a cycle with `en` && `in_valid` && `in_first` && `pend_flag`, set `bright_act` ← `bright_pend` and `pend_flag` ← 0. The committing word itself uses the new value, applied combinationally at the stage-1 tag.
- Load and commit in the same cycle:
  - The commit uses the old `bright_pend`.
  - The load wins for `bright_pend`, and `pend_flag` stays 1.
- Brightness B and `gamma_en` are captured into stage 1 together with the pixel. Later changes to `bright_act` or `gamma_en` do not affect words already in flight.

## Timing
- Stages:
  - S1 registers `pixel`, `in_valid`, `in_first`, the B tag and the `gamma_en` tag.
  - S2 registers g and forwards the tags.
  - S3 registers `cpixel`, `out_valid` and `out_first`.
- Latency is 3 `en`-qualified cycles: a word presented with `en`=1 on edge k appears on `cpixel` after edge k+2 (both counted in `en`=1 edges).
- With `en` continuously 1, throughput is 1 word per cycle.
- `en`=0 freezes every stage, including the valid bits. Outputs hold their last value. The brightness commit is blocked, but loads into `bright_pend` still occur.
- `in_valid`=0 with `en`=1 inserts a bubble. Data registers may load don't-care values, but `out_valid` is 0 for that slot.
- `cpixel` changes only on a rising edge with `en`=1. When `out_valid`=0 its content is unspecified, except after reset.
- Reset (`rst_n`=0):
  - Asynchronously clears all stage registers.
  - Outputs go to `out_valid`=0, `out_first`=0, `cpixel`=0.
  - Brightness registers return to their reset values.
  - Reset mid-stream discards all in-flight words; nothing partial is emitted after release.

## Test plan
- Default brightness (0xFF), gamma on, `en`=1: pixel {FFFFFF, 000000} → cpixel {FFFFFF, 000000} with `out_valid`=1 exactly 3 cycles later. Channel 0x80 → 0x40; 0x10 → 0x01.
- Gamma off, brightness loaded as 0x7F and committed with an `in_first` word: 0xFF → 0x7F; 0x80 → 0x40. A load with no `in_first` following leaves the output unchanged at 0xFF.
- Frame sync: load 0x3F mid-frame. Words before the next `in_first` keep B=0xFF. From the `in_first` word onward, 0xFF → 0x3F; `out_first` is aligned with that word.
- Stall: assert `in_valid` on 3 back-to-back words, then drop `en` for 4 cycles mid-stream. The output sequence and order are unchanged. `out_valid` holds and `cpixel` is stable during the stall. Bubbles (`in_valid`=0) yield `out_valid`=0 slots.
- `out_bits`=5, `segments`=4, gamma on, B=0xFF: channel 0xFF → 0x1F; 0x00 → 0x00; 0x80 → 0x08. Lane ordering is verified with distinct per-segment values.
- Pull `rst_n` low asynchronously (mid-clock) with 3 words in flight. `out_valid`, `out_first` and `cpixel` go to 0 immediately. After release, no stale word appears and brightness is back to 0xFF.
